// File: rtl/fp_pkg.sv
// Shared constants and payload layout for the pipelined float add/sub unit.
package fp_pkg;

  localparam int EW_DEF = 4;
  localparam int FW_DEF = 8;
  localparam int TW_DEF = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic ovf;
    logic unf;
  } fp_flags_t;

  // Result payload as it leaves the last stage: {tag, sign, exp, frac, flags}.
  localparam int PAYLOAD_W = TW_DEF + 1 + EW_DEF + FW_DEF + $bits(fp_flags_t);

endpackage

// File: rtl/fp_adder_pipe_if.sv
// Operand-issue and result-writeback handshake bundle for fp_adder_pipe.
interface fp_adder_pipe_if import fp_pkg::*; #(
  parameter int EW = EW_DEF,
  parameter int FW = FW_DEF,
  parameter int TW = TW_DEF
);
  logic          in_valid;
  logic          in_ready;
  logic          in_op;
  logic [TW-1:0] in_tag;
  logic          a_sign;
  logic          b_sign;
  logic [EW-1:0] a_exp;
  logic [EW-1:0] b_exp;
  logic [FW-1:0] a_frac;
  logic [FW-1:0] b_frac;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_tag;
  logic          out_sign;
  logic [EW-1:0] out_exp;
  logic [FW-1:0] out_frac;
  logic          out_ovf;
  logic          out_unf;

  modport master (
    output in_valid, in_op, in_tag, a_sign, b_sign, a_exp, b_exp, a_frac, b_frac, out_ready,
    input  in_ready, out_valid, out_tag, out_sign, out_exp, out_frac, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_op, in_tag, a_sign, b_sign, a_exp, b_exp, a_frac, b_frac, out_ready,
    output in_ready, out_valid, out_tag, out_sign, out_exp, out_frac, out_ovf, out_unf
  );
endinterface

// File: rtl/fp_lead0_cnt.sv
// Combinational leading-zero count of an FW-bit word; returns FW for an all-zero word.
module fp_lead0_cnt #(
  parameter int FW = 8,
  localparam int CW = $clog2(FW + 1)
) (
  input  logic [FW-1:0] value,
  output logic [CW-1:0] count
);
  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = CW'(FW);
    for (int i = 0; i < FW; i++) begin
      if (value[i]) count = CW'(FW - 1 - i);
    end
  end
endmodule

// File: rtl/fp_adder_pipe.sv
// Four-stage pipelined float add/sub: sort, align, add, normalise.
// Each stage holds one op; backpressure ripples back from the output register.
module fp_adder_pipe import fp_pkg::*; #(
  parameter int EW = EW_DEF,
  parameter int FW = FW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  fp_adder_pipe_if.slave bus
);
  localparam int LZW = $clog2(FW + 1);

  logic adv1, adv2, adv3, adv4;
  logic s1_valid, s2_valid, s3_valid, s4_valid;

  logic [TW-1:0] s1_tag, s2_tag, s3_tag, s4_tag;
  logic          s1_sign_b, s1_sign_s, s2_sign_b, s2_sign_s, s3_sign_b, s4_sign;
  logic [EW-1:0] s1_exp_b, s1_exp_s, s2_exp_b, s3_exp_b, s4_exp;
  logic [FW-1:0] s1_frac_b, s1_frac_s, s2_frac_b, s2_frac_s, s4_frac;
  logic [FW:0]   s3_sum;
  fp_flags_t     s4_flags;

  assign adv4 = !s4_valid || bus.out_ready;
  assign adv3 = !s3_valid || adv4;
  assign adv2 = !s2_valid || adv3;
  assign adv1 = !s1_valid || adv2;
  assign bus.in_ready = adv1;

  // Sort: ties go to b so equal magnitudes subtract to an exact zero.
  logic b_sign_eff, a_big;
  assign b_sign_eff = bus.b_sign ^ (bus.in_op == OP_SUB);
  assign a_big      = {bus.a_exp, bus.a_frac} > {bus.b_exp, bus.b_frac};

  logic [EW-1:0] diff;
  logic [FW-1:0] frac_s_al;
  assign diff      = s1_exp_b - s1_exp_s;
  assign frac_s_al = (int'(diff) >= FW) ? '0 : (s1_frac_s >> diff);

  logic [FW:0] sum;
  assign sum = (s2_sign_b == s2_sign_s) ? ({1'b0, s2_frac_b} + {1'b0, s2_frac_s})
                                        : ({1'b0, s2_frac_b} - {1'b0, s2_frac_s});

  logic [LZW-1:0] lead0;
  fp_lead0_cnt #(.FW(FW)) u_lead0 (.value(s3_sum[FW-1:0]), .count(lead0));

  logic          n_sign;
  logic [EW-1:0] n_exp;
  logic [FW-1:0] n_frac;
  fp_flags_t     n_flags;

  always_comb begin
    n_sign  = s3_sign_b;
    n_exp   = '0;
    n_frac  = '0;
    n_flags = '0;
    if (s3_sum == '0) begin
      n_sign = 1'b0;
    end else if (s3_sum[FW]) begin
      if (&s3_exp_b) begin
        n_exp       = '1;
        n_frac      = '1;
        n_flags.ovf = 1'b1;
      end else begin
        n_exp  = s3_exp_b + EW'(1);
        n_frac = s3_sum[FW:1];
      end
    end else if (int'(lead0) > int'(s3_exp_b)) begin
      n_sign      = 1'b0;
      n_flags.unf = 1'b1;
    end else begin
      n_exp  = s3_exp_b - EW'(lead0);
      n_frac = s3_sum[FW-1:0] << lead0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s4_valid <= 1'b0;
    end else begin
      if (adv1) s1_valid <= bus.in_valid;
      if (adv2) s2_valid <= s1_valid;
      if (adv3) s3_valid <= s2_valid;
      if (adv4) s4_valid <= s3_valid;
    end
  end

  // Data registers only load behind a valid op, so a stalled or drained output stays put.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_tag <= '0; s1_sign_b <= 1'b0; s1_sign_s <= 1'b0;
      s1_exp_b <= '0; s1_exp_s <= '0; s1_frac_b <= '0; s1_frac_s <= '0;
      s2_tag <= '0; s2_sign_b <= 1'b0; s2_sign_s <= 1'b0;
      s2_exp_b <= '0; s2_frac_b <= '0; s2_frac_s <= '0;
      s3_tag <= '0; s3_sign_b <= 1'b0; s3_exp_b <= '0; s3_sum <= '0;
      s4_tag <= '0; s4_sign <= 1'b0; s4_exp <= '0; s4_frac <= '0; s4_flags <= '0;
    end else begin
      if (adv1 && bus.in_valid) begin
        s1_tag    <= bus.in_tag;
        s1_sign_b <= a_big ? bus.a_sign : b_sign_eff;
        s1_sign_s <= a_big ? b_sign_eff : bus.a_sign;
        s1_exp_b  <= a_big ? bus.a_exp  : bus.b_exp;
        s1_exp_s  <= a_big ? bus.b_exp  : bus.a_exp;
        s1_frac_b <= a_big ? bus.a_frac : bus.b_frac;
        s1_frac_s <= a_big ? bus.b_frac : bus.a_frac;
      end
      if (adv2 && s1_valid) begin
        s2_tag    <= s1_tag;
        s2_sign_b <= s1_sign_b;
        s2_sign_s <= s1_sign_s;
        s2_exp_b  <= s1_exp_b;
        s2_frac_b <= s1_frac_b;
        s2_frac_s <= frac_s_al;
      end
      if (adv3 && s2_valid) begin
        s3_tag    <= s2_tag;
        s3_sign_b <= s2_sign_b;
        s3_exp_b  <= s2_exp_b;
        s3_sum    <= sum;
      end
      if (adv4 && s3_valid) begin
        s4_tag   <= s3_tag;
        s4_sign  <= n_sign;
        s4_exp   <= n_exp;
        s4_frac  <= n_frac;
        s4_flags <= n_flags;
      end
    end
  end

  assign bus.out_valid = s4_valid;
  assign bus.out_tag   = s4_tag;
  assign bus.out_sign  = s4_sign;
  assign bus.out_exp   = s4_exp;
  assign bus.out_frac  = s4_frac;
  assign bus.out_ovf   = s4_flags.ovf;
  assign bus.out_unf   = s4_flags.unf;

endmodule
